// File: rtl/axi_page_rd_sched_if.sv
// Bus bundle for the page-ring scheduler: writer status, reader command/ack and
// ring occupancy. The scheduler takes the slave view; the environment takes the master view.
interface axi_page_rd_sched_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned PAGE_NUM   = 16
);
  localparam int unsigned CW = $clog2(PAGE_NUM + 1);

  logic                  i_wr_done;
  logic [ADDR_WIDTH-1:0] o_wr_addr;
  logic                  o_wr_allow;
  logic                  o_rd_req;
  logic [ADDR_WIDTH-1:0] o_rd_addr;
  logic                  i_rd_ack;
  logic                  i_rd_done;
  logic [CW-1:0]         o_used;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_ovf;
  logic                  i_clr_ovf;

  modport slave (
    input  i_wr_done, i_rd_ack, i_rd_done, i_clr_ovf,
    output o_wr_addr, o_wr_allow, o_rd_req, o_rd_addr, o_used, o_full, o_empty, o_ovf
  );

  modport master (
    output i_wr_done, i_rd_ack, i_rd_done, i_clr_ovf,
    input  o_wr_addr, o_wr_allow, o_rd_req, o_rd_addr, o_used, o_full, o_empty, o_ovf
  );
endinterface

// File: rtl/axi_page_rd_sched.sv
// Page-ring scheduler for the DDR frame buffer: hands the writer its next page,
// issues one read command at a time and frees pages in write order.
module axi_page_rd_sched #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  START_ADDR = '0,
  parameter int unsigned            PAGE_BYTES = 4096,
  parameter int unsigned            PAGE_NUM   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  axi_page_rd_sched_if.slave     bus
);
  localparam int unsigned CW = $clog2(PAGE_NUM + 1);
  localparam int unsigned PW = $clog2(PAGE_NUM);

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  state_t                state, state_n;
  logic [PW-1:0]         wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CW-1:0]         used, used_n, pend, pend_n;
  logic                  rd_req, rd_req_n, ovf, ovf_n;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_n, rd_addr, rd_addr_n;
  logic                  full, wr_acc, ack_acc, rd_fin;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(PAGE_NUM - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] page_addr(input logic [PW-1:0] p);
    return START_ADDR + ADDR_WIDTH'(p) * ADDR_WIDTH'(PAGE_BYTES);
  endfunction

  always_comb begin
    full      = (used == CW'(PAGE_NUM));
    wr_acc    = bus.i_wr_done && !full;
    ack_acc   = (state == REQ) && bus.i_rd_ack;
    rd_fin    = (state == BUSY) && bus.i_rd_done;
    wr_ptr_n  = wr_acc ? ptr_inc(wr_ptr) : wr_ptr;
    wr_addr_n = page_addr(wr_ptr_n);
    used_n    = used + CW'(wr_acc) - CW'(rd_fin);
    pend_n    = pend + CW'(wr_acc) - CW'(ack_acc);
    // A rejected write sets overflow even when a clear arrives on the same edge
    if (bus.i_wr_done && full) ovf_n = 1'b1;
    else if (bus.i_clr_ovf)    ovf_n = 1'b0;
    else                       ovf_n = ovf;

    state_n   = state;
    rd_req_n  = rd_req;
    rd_addr_n = rd_addr;
    rd_ptr_n  = rd_ptr;
    case (state)
      IDLE: if (pend != '0) begin
        state_n   = REQ;
        rd_req_n  = 1'b1;
        rd_addr_n = page_addr(rd_ptr);
      end
      REQ: if (bus.i_rd_ack) begin
        state_n  = BUSY;
        rd_req_n = 1'b0;
        rd_ptr_n = ptr_inc(rd_ptr);
      end
      BUSY: if (bus.i_rd_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      used    <= '0;
      pend    <= '0;
      rd_req  <= 1'b0;
      ovf     <= 1'b0;
      wr_addr <= START_ADDR;
      rd_addr <= START_ADDR;
    end else begin
      state   <= state_n;
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      used    <= used_n;
      pend    <= pend_n;
      rd_req  <= rd_req_n;
      ovf     <= ovf_n;
      wr_addr <= wr_addr_n;
      rd_addr <= rd_addr_n;
    end
  end

  assign bus.o_wr_addr  = wr_addr;
  assign bus.o_wr_allow = !full;
  assign bus.o_rd_req   = rd_req;
  assign bus.o_rd_addr  = rd_addr;
  assign bus.o_used     = used;
  assign bus.o_full     = full;
  assign bus.o_empty    = (used == '0);
  assign bus.o_ovf      = ovf;
endmodule

// File: tb/tb_axi_page_rd_sched.sv
// Scoreboard bench for axi_page_rd_sched: stimulus pushes expected read addresses,
// a monitor tracks ring occupancy at page level and checks every cycle.
module tb_axi_page_rd_sched;
  localparam int          AW = 32;
  localparam int          PN = 16;
  localparam int          PB = 4096;
  localparam logic [31:0] SA = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_page_rd_sched_if #(.ADDR_WIDTH(AW), .PAGE_NUM(PN)) bus();

  axi_page_rd_sched #(
    .ADDR_WIDTH(AW), .START_ADDR(SA), .PAGE_BYTES(PB), .PAGE_NUM(PN)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pages held, pages waiting for the reader, job outstanding
  int              m_used, m_pend, m_widx, stall, hs_count;
  bit              m_inflight, m_ovf;
  logic [AW-1:0]   exp_q[$];

  function automatic logic [AW-1:0] pg(input int idx);
    return SA + AW'(idx * PB);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit wr, input bit ack, input bit done, input bit clr);
    @(negedge clk);
    bus.i_wr_done = wr;
    bus.i_rd_ack  = ack;
    bus.i_rd_done = done;
    bus.i_clr_ovf = clr;
    if (wr && !rst && m_used < PN) exp_q.push_back(pg(m_widx));
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.i_wr_done = 1'b0;
    bus.i_rd_ack  = 1'b0;
    bus.i_rd_done = 1'b0;
    bus.i_clr_ovf = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_used", bus.o_used, 0);
    chk("rst_rd_req", bus.o_rd_req, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic serve();
    int w = 0;
    while (!bus.o_rd_req && w < 5) begin
      cyc(0, 0, 0, 0);
      w++;
    end
    if (!bus.o_rd_req) begin
      checks++;
      errors++;
      $display("FAIL serve_timeout: got rd_req=0 want 1 within 5 cycles");
    end else begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
    end
  endtask

  // Monitor: compare against the model, then advance the model by the coming edge
  always begin
    bit wr, ack, done, clr, wacc, aacc, fin;
    logic [AW-1:0] e;
    @(negedge clk);
    #2;
    if (rst) begin
      chk("reset_used", bus.o_used, 0);
      chk("reset_empty", bus.o_empty, 1);
      chk("reset_full", bus.o_full, 0);
      chk("reset_allow", bus.o_wr_allow, 1);
      chk("reset_ovf", bus.o_ovf, 0);
      chk("reset_req", bus.o_rd_req, 0);
      chk("reset_wr_addr", bus.o_wr_addr, SA);
      chk("reset_rd_addr", bus.o_rd_addr, SA);
      m_used = 0; m_pend = 0; m_widx = 0; stall = 0;
      m_inflight = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      chk("used", bus.o_used, m_used);
      chk("full", bus.o_full, m_used == PN);
      chk("empty", bus.o_empty, m_used == 0);
      chk("wr_allow", bus.o_wr_allow, m_used != PN);
      chk("ovf", bus.o_ovf, m_ovf);
      chk("wr_addr", bus.o_wr_addr, pg(m_widx));
      if (bus.o_rd_req) begin
        stall = 0;
        chk("req_legal", (m_pend > 0) && !m_inflight, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected: got rd_req=1 addr %0h want no command", bus.o_rd_addr);
        end else begin
          chk("rd_addr_hold", bus.o_rd_addr, exp_q[0]);
        end
      end else if (m_pend > 0 && !m_inflight) begin
        stall++;
        chk("req_late", stall > 1, 0);
      end else begin
        stall = 0;
      end

      wr   = bus.i_wr_done;
      ack  = bus.i_rd_ack;
      done = bus.i_rd_done;
      clr  = bus.i_clr_ovf;
      wacc = wr && (m_used < PN);
      aacc = ack && bus.o_rd_req;
      fin  = done && m_inflight;
      if (wr && m_used == PN) m_ovf = 1;
      else if (clr)           m_ovf = 0;
      if (aacc) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_cmd: got addr %0h want no command", bus.o_rd_addr);
        end else begin
          e = exp_q.pop_front();
          chk("rd_cmd_addr", bus.o_rd_addr, e);
        end
      end
      m_used = m_used + int'(wacc) - int'(fin);
      m_pend = m_pend + int'(wacc) - int'(aacc);
      if (aacc)     m_inflight = 1;
      else if (fin) m_inflight = 0;
      if (wacc) m_widx = (m_widx + 1) % PN;
    end
  end

  initial begin
    bus.i_wr_done = 1'b0;
    bus.i_rd_ack  = 1'b0;
    bus.i_rd_done = 1'b0;
    bus.i_clr_ovf = 1'b0;
    hs_count = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single page latency and release
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("single_used", bus.o_used, 1);
    chk("single_req_early", bus.o_rd_req, 0);
    cyc(0, 0, 0, 0);
    chk("single_req", bus.o_rd_req, 1);
    chk("single_addr", bus.o_rd_addr, 32'h0000);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("single_busy_req", bus.o_rd_req, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("single_freed", bus.o_used, 0);
    chk("single_empty", bus.o_empty, 1);

    // Reset while a job is outstanding
    cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    do_reset();

    // Fill the ring with the reader stalled, then overflow
    for (int i = 0; i < PN; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("fill_full", bus.o_full, 1);
    chk("fill_allow", bus.o_wr_allow, 0);
    chk("fill_wr_addr", bus.o_wr_addr, 32'h0000);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, i % 2, 0);
      chk("hold_req", bus.o_rd_req, 1);
      chk("hold_addr", bus.o_rd_addr, 32'h0000);
    end
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("ovf_set", bus.o_ovf, 1);
    chk("ovf_used", bus.o_used, 16);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("ovf_clr", bus.o_ovf, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("full_wr_done_used", bus.o_used, 15);
    chk("full_wr_done_ovf", bus.o_ovf, 1);
    for (int i = 0; i < 15; i++) serve();
    cyc(0, 0, 0, 0);
    chk("drain_empty", bus.o_empty, 1);

    // Simultaneous write and release at three pages
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("simul_used", bus.o_used, 3);
    for (int i = 0; i < 3; i++) serve();

    // Stream 20 pages through the ring to cover pointer wrap
    do_reset();
    hs_count = 0;
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0);
      serve();
    end
    cyc(0, 0, 0, 0);
    chk("wrap_handshakes", hs_count, 20);
    chk("wrap_wr_addr", bus.o_wr_addr, 32'h4000);
    chk("wrap_ovf", bus.o_ovf, 0);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(999) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(2) == 0, $urandom_range(1) == 0,
            $urandom_range(3) == 0, $urandom_range(49) == 0);
      end
    end
    repeat (3) cyc(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
